// File: rtl/gate_model_pipe_bist.sv
// Pipelined mixing-network gate model with LFSR/MISR built-in self-test.
// Define GATE_MODEL_FAULT_EN to add stuck-at fault injection ports on the stage registers.
module gate_model_pipe_bist #(
  parameter int unsigned      N_IN      = 24,
  parameter int unsigned      N_OUT     = 10,
  parameter int unsigned      STAGES    = 4,
  parameter int unsigned      PATTERNS  = 256,
  parameter logic [N_IN-1:0]  LFSR_SEED = '1,
  parameter logic [N_OUT-1:0] MISR_TAPS = N_OUT'(10'h009)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_IN-1:0]           in_data,
  input  logic                      in_valid,
  input  logic                      hold,
`ifdef GATE_MODEL_FAULT_EN
  input  logic                      fault_en,
  input  logic [$clog2(STAGES):0]   fault_stage,
  input  logic [$clog2(N_IN)-1:0]   fault_bit,
  input  logic                      fault_val,
`endif
  output logic [N_OUT-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      bist_start,
  output logic                      bist_busy,
  output logic                      bist_done,
  output logic [N_OUT-1:0]          bist_signature
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [15:0]    PAT_LAST   = 16'(PATTERNS - 1);
  localparam logic [3:0]     DRAIN_LAST = 4'(STAGES - 1);
  // Words narrower than 8 bits have no N_IN-8 tap; bit 0 stands in for it.
  localparam int unsigned    TAP_D      = (N_IN >= 8) ? N_IN - 8 : 0;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    pipe_q [STAGES];
  logic [N_IN-1:0]    pipe_d [STAGES];
  logic [STAGES-1:0]  vld_q, vld_d;
  logic [N_IN-1:0]    lfsr_q, lfsr_d, lfsr_next;
  logic [N_OUT-1:0]   misr_q, misr_d, misr_next;
  logic [15:0]        pat_cnt_q, pat_cnt_d;
  logic [3:0]         drain_cnt_q, drain_cnt_d;
  logic [N_IN-1:0]    s0_data;
  logic               s0_vld;
  logic               src_lfsr, src_ext;
  logic               start_fire;

  function automatic logic [N_IN-1:0] rotl(input logic [N_IN-1:0] w, input int unsigned k);
    return (w << k) | (w >> (N_IN - k));
  endfunction

  function automatic logic [N_IN-1:0] mix(input logic [N_IN-1:0] w, input int unsigned s);
    return rotl(w, 1) ^ (rotl(w, 2) & ~rotl(w, 5)) ^ N_IN'(s);
  endfunction

  function automatic logic [N_OUT-1:0] fold(input logic [N_IN-1:0] w);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < N_IN; j++) begin
      r[j % N_OUT] = r[j % N_OUT] ^ w[j];
    end
    return r;
  endfunction

  assign start_fire = bist_start && !hold && ((state_q == S_IDLE) || (state_q == S_DONE));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else if (!hold) begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_fire) state_d = S_RUN;
      S_RUN:   if (pat_cnt_q == PAT_LAST) state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE: begin
        if (start_fire)    state_d = S_RUN;
        else if (in_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and stage-0 source select
  always_comb begin
    bist_busy = 1'b0;
    bist_done = 1'b0;
    src_lfsr  = 1'b0;
    src_ext   = 1'b0;
    unique case (state_q)
      S_IDLE:  src_ext = 1'b1;
      S_RUN: begin
        bist_busy = 1'b1;
        src_lfsr  = 1'b1;
      end
      S_DRAIN: bist_busy = 1'b1;
      S_DONE: begin
        bist_done = 1'b1;
        src_ext   = 1'b1;
      end
      default: ;
    endcase
  end

  // Mixing network: each stage register holds the mix of the previous one
  always_comb begin
    s0_data = '0;
    s0_vld  = 1'b0;
    if (src_lfsr) begin
      s0_data = lfsr_q;
      s0_vld  = 1'b1;
    end else if (src_ext) begin
      s0_data = in_data;
      s0_vld  = in_valid;
    end

    pipe_d[0] = mix(s0_data, 0);
    vld_d[0]  = s0_vld;
    for (int unsigned s = 1; s < STAGES; s++) begin
      pipe_d[s] = mix(pipe_q[s-1], s);
      vld_d[s]  = vld_q[s-1];
    end

`ifdef GATE_MODEL_FAULT_EN
    if (fault_en) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if ((32'(fault_stage) == s) && (32'(fault_bit) < N_IN)) begin
          pipe_d[s][fault_bit] = fault_val;
        end
      end
    end
`endif

    // A BIST start flushes anything in flight so the signature sees only patterns.
    if (start_fire) vld_d = '0;
  end

  assign lfsr_next = {lfsr_q[N_IN-2:0],
                      lfsr_q[N_IN-1] ^ lfsr_q[N_IN-2] ^ lfsr_q[N_IN-3] ^ lfsr_q[TAP_D]};
  assign misr_next = {misr_q[N_OUT-2:0], misr_q[N_OUT-1]}
                   ^ (misr_q[N_OUT-1] ? MISR_TAPS : '0)
                   ^ out_data;

  always_comb begin
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    pat_cnt_d   = pat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (start_fire) begin
      lfsr_d    = LFSR_SEED;
      misr_d    = '0;
      pat_cnt_d = '0;
    end else begin
      if (src_lfsr) begin
        lfsr_d      = lfsr_next;
        drain_cnt_d = '0;
        if (pat_cnt_q != '1) pat_cnt_d = pat_cnt_q + 16'd1;
      end
      if (state_q == S_DRAIN) drain_cnt_d = drain_cnt_q + 4'd1;
      if (bist_busy && out_valid) misr_d = misr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q      <= '{default: '0};
      vld_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      misr_q      <= '0;
      pat_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else if (!hold) begin
      pipe_q      <= pipe_d;
      vld_q       <= vld_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      pat_cnt_q   <= pat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign out_data       = fold(pipe_q[STAGES-1]);
  assign out_valid      = vld_q[STAGES-1];
  assign bist_signature = misr_q;

endmodule

// File: tb/tb_gate_model_pipe_bist.sv
// Directed self-checking bench for gate_model_pipe_bist at default parameters.
module tb_gate_model_pipe_bist;

  logic        clk;
  logic        rst_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        hold;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        bist_start;
  logic        bist_busy;
  logic        bist_done;
  logic [9:0]  bist_signature;
`ifdef GATE_MODEL_FAULT_EN
  logic        fault_en;
  logic [2:0]  fault_stage;
  logic [4:0]  fault_bit;
  logic        fault_val;
`endif

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_sig;

  gate_model_pipe_bist #(
    .N_IN     (24),
    .N_OUT    (10),
    .STAGES   (4),
    .PATTERNS (256),
    .LFSR_SEED(24'hFFFFFF),
    .MISR_TAPS(10'h009)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .hold          (hold),
`ifdef GATE_MODEL_FAULT_EN
    .fault_en      (fault_en),
    .fault_stage   (fault_stage),
    .fault_bit     (fault_bit),
    .fault_val     (fault_val),
`endif
    .out_data      (out_data),
    .out_valid     (out_valid),
    .bist_start    (bist_start),
    .bist_busy     (bist_busy),
    .bist_done     (bist_done),
    .bist_signature(bist_signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, written bit-by-bit from the behavioural description
  function automatic logic [23:0] t_rotl(input logic [23:0] w, input int k);
    logic [23:0] r;
    for (int i = 0; i < 24; i++) r[(i + k) % 24] = w[i];
    return r;
  endfunction

  function automatic logic [23:0] t_net(input logic [23:0] w0);
    logic [23:0] w;
    w = w0;
    for (int s = 0; s < 4; s++) w = t_rotl(w, 1) ^ (t_rotl(w, 2) & ~t_rotl(w, 5)) ^ 24'(s);
    return w;
  endfunction

  function automatic logic [9:0] t_fold(input logic [23:0] w);
    logic [9:0] r;
    r = '0;
    for (int j = 0; j < 24; j++) r[j % 10] = r[j % 10] ^ w[j];
    return r;
  endfunction

  function automatic logic [9:0] t_sig();
    logic [23:0] l;
    logic [9:0]  s;
    logic [9:0]  o;
    l = 24'hFFFFFF;
    s = '0;
    for (int p = 0; p < 256; p++) begin
      o = t_fold(t_net(l));
      s = {s[8:0], s[9]} ^ (s[9] ? 10'h009 : 10'h000) ^ o;
      l = {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bist_busy && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; hold = 1'b0; bist_start = 1'b0;
`ifdef GATE_MODEL_FAULT_EN
    fault_en = 1'b0; fault_stage = '0; fault_bit = '0; fault_val = 1'b0;
`endif
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 10'h000) begin failures++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
    checks++; if (bist_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bist_busy); end
    checks++; if (bist_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bist_done); end
    checks++; if (bist_signature !== 10'h000) begin failures++; $display("FAIL reset_sig got=%h exp=000", bist_signature); end
    #5 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0);
      in_data  = '0;
      checks++;
      if (out_valid !== 1'(c == 4)) begin failures++; $display("FAIL latency_valid c=%0d got=%b exp=%b", c, out_valid, (c == 4)); end
      if (c == 4) begin
        checks++;
        if (out_data !== 10'h01B) begin failures++; $display("FAIL latency_data got=%h exp=01b", out_data); end
      end
      tick();
    end
  endtask

  task automatic test_vectors();
    logic [23:0] vec [2];
    logic [9:0]  exp [2];
    vec[0] = 24'h000001; exp[0] = 10'h08B;
    vec[1] = 24'h800000; exp[1] = 10'h053;
    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c < 6; c++) begin
        in_valid = (c == 0);
        in_data  = vec[v];
        if (c == 4) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== exp[v]) begin
            failures++; $display("FAIL vector%0d got=%b/%h exp=1/%h", v, out_valid, out_data, exp[v]);
          end
        end
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] tbl [8];
    logic [9:0]  e;
    tbl[0] = 24'h123456; tbl[1] = 24'hFFFFFF; tbl[2] = 24'hA5A5A5; tbl[3] = 24'h000400;
    tbl[4] = 24'hFEDCBA; tbl[5] = 24'h0F0F0F; tbl[6] = 24'h800001; tbl[7] = 24'h3C00C3;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      in_data  = (c < 8) ? tbl[c] : 24'h0;
      checks++;
      if (out_valid !== 1'(c >= 4 && c < 12)) begin failures++; $display("FAIL b2b_valid c=%0d got=%b", c, out_valid); end
      if (c >= 4 && c < 12) begin
        e = t_fold(t_net(tbl[c-4]));
        checks++;
        if (out_data !== e) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, out_data, e); end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [23:0] tbl [8];
    logic [9:0]  e;
    int          idx;
    tbl[0] = 24'h111111; tbl[1] = 24'h2468AC; tbl[2] = 24'hC0FFEE; tbl[3] = 24'h000003;
    tbl[4] = 24'h7FFFFF; tbl[5] = 24'h5A5A00; tbl[6] = 24'h00F00F; tbl[7] = 24'h987654;
    for (int c = 0; c < 17; c++) begin
      hold = (c >= 5 && c <= 7);
      if (c < 5)       begin in_valid = 1'b1; in_data = tbl[c];      end
      else if (c < 8)  begin in_valid = 1'b1; in_data = 24'hABCDEF;  end
      else if (c < 11) begin in_valid = 1'b1; in_data = tbl[c-3];    end
      else             begin in_valid = 1'b0; in_data = 24'h0;       end
      if (c == 4)                 idx = 0;
      else if (c >= 5 && c <= 8)  idx = 1;
      else if (c >= 9 && c <= 14) idx = c - 7;
      else                        idx = -1;
      checks++;
      if (out_valid !== 1'(idx >= 0)) begin failures++; $display("FAIL hold_valid c=%0d got=%b", c, out_valid); end
      if (idx >= 0) begin
        e = t_fold(t_net(tbl[idx]));
        checks++;
        if (out_data !== e) begin failures++; $display("FAIL hold_data c=%0d got=%h exp=%h", c, out_data, e); end
      end
      tick();
    end
    hold = 1'b0;
  endtask

  task automatic test_hold_start();
    hold = 1'b1; bist_start = 1'b1;
    tick();
    hold = 1'b0; bist_start = 1'b0;
    checks++; if (bist_busy !== 1'b0) begin failures++; $display("FAIL hold_start_busy got=%b exp=0", bist_busy); end
    tick();
    checks++; if (bist_busy !== 1'b0 || bist_done !== 1'b0) begin failures++; $display("FAIL hold_start_idle got=%b%b exp=00", bist_busy, bist_done); end
  endtask

  task automatic test_bist_run();
    int n;
    pulse_start();
    wait_busy(n);
    checks++; if (n != 260) begin failures++; $display("FAIL bist_busy_cycles got=%0d exp=260", n); end
    checks++; if (bist_done !== 1'b1) begin failures++; $display("FAIL bist_done got=%b exp=1", bist_done); end
    checks++; if (bist_signature !== exp_sig) begin failures++; $display("FAIL bist_sig got=%h exp=%h", bist_signature, exp_sig); end
    repeat (3) tick();
    checks++; if (bist_done !== 1'b1 || bist_signature !== exp_sig) begin
      failures++; $display("FAIL bist_sig_stable got=%b/%h exp=1/%h", bist_done, bist_signature, exp_sig);
    end
  endtask

  task automatic test_bist_rerun();
    int n;
    int i;
    pulse_start();
    n = 0; i = 0;
    while (bist_busy && i < 2000) begin
      in_valid   = 1'b1;
      in_data    = 24'(i * 32'h9E3779);
      bist_start = (i == 40);
      hold       = (i >= 100 && i < 103);
      n++; i++;
      tick();
    end
    in_valid = 1'b0; bist_start = 1'b0; hold = 1'b0;
    checks++; if (n != 263) begin failures++; $display("FAIL rerun_busy_cycles got=%0d exp=263", n); end
    checks++; if (bist_signature !== exp_sig) begin failures++; $display("FAIL rerun_sig got=%h exp=%h", bist_signature, exp_sig); end
  endtask

  task automatic test_done_to_idle();
    checks++; if (bist_done !== 1'b1) begin failures++; $display("FAIL d2i_pre_done got=%b exp=1", bist_done); end
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0);
      in_data  = '0;
      if (c == 1) begin
        checks++; if (bist_done !== 1'b0) begin failures++; $display("FAIL d2i_done got=%b exp=0", bist_done); end
      end
      checks++;
      if (out_valid !== 1'(c == 4)) begin failures++; $display("FAIL d2i_valid c=%0d got=%b", c, out_valid); end
      if (c == 4) begin
        checks++; if (out_data !== 10'h01B) begin failures++; $display("FAIL d2i_data got=%h exp=01b", out_data); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    pulse_start();
    repeat (50) tick();
    checks++; if (bist_busy !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%b exp=1", bist_busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bist_busy !== 1'b0 || bist_done !== 1'b0) begin failures++; $display("FAIL midrun_rst_state got=%b%b exp=00", bist_busy, bist_done); end
    checks++; if (bist_signature !== 10'h000) begin failures++; $display("FAIL midrun_rst_sig got=%h exp=000", bist_signature); end
    checks++; if (out_valid !== 1'b0 || out_data !== 10'h000) begin failures++; $display("FAIL midrun_rst_out got=%b/%h exp=0/000", out_valid, out_data); end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_busy(n);
    checks++; if (n != 260) begin failures++; $display("FAIL post_rst_busy_cycles got=%0d exp=260", n); end
    checks++; if (bist_signature !== exp_sig) begin failures++; $display("FAIL post_rst_sig got=%h exp=%h", bist_signature, exp_sig); end
  endtask

`ifdef GATE_MODEL_FAULT_EN
  task automatic test_fault();
    int n;
    fault_en = 1'b1; fault_stage = 3'd0; fault_bit = 5'd0; fault_val = 1'b1;
    pulse_start();
    wait_busy(n);
    checks++; if (bist_signature === exp_sig) begin failures++; $display("FAIL fault_sig got=%h must differ from %h", bist_signature, exp_sig); end
    fault_en = 1'b0;
  endtask
`endif

  initial begin
    exp_sig = t_sig();
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_hold();
    test_hold_start();
    test_bist_run();
    test_bist_rerun();
    test_done_to_idle();
    test_reset_mid_run();
`ifdef GATE_MODEL_FAULT_EN
    test_fault();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
